// File: rtl/frame_pattern_decoder.sv
// SDCKA/SDCKB edge-pattern decoder: counts edges between open/close strobes and pulses the decoded result.
// Optional pattern timeout is compiled in with `define FRAME_DECODER_TIMEOUT_EN.
module frame_pattern_decoder #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             sdcka_posedge,
    input  logic             sdcka_negedge,
    input  logic             sdckb_posedge,
    input  logic             sdckb_negedge,
    output logic             start_frame,
    output logic             start_with_crc,
    output logic             start_occupancy,
    output logic             start_reset,
    output logic             end_frame,
    output logic             pattern_error,
    output logic             timeout_error,
    output logic             busy,
    output logic [CNT_W-1:0] last_count
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        START_CNT = 4'b0010,
        END_CNT   = 4'b0100,
        DONE      = 4'b1000
    } state_t;

    // Decode pulse bits: [0] frame, [1] crc, [2] occupancy, [3] reset, [4] end, [5] error
    state_t           state_q = IDLE;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q   = '0;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_eval;
    logic [5:0]       pulse_q = '0;
    logic [5:0]       pulse_d;
    logic             busy_q  = 1'b0;
    logic             busy_d;
    logic [CNT_W-1:0] last_q  = '0;
    logic [CNT_W-1:0] last_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [5:0] decode_start(input logic [CNT_W-1:0] n);
        logic [31:0] v;
        v = 32'(n);
        case (v)
            32'd0, 32'd1: return 6'b000000;
            32'd4:        return 6'b000001;
            32'd6:        return 6'b000010;
            32'd8:        return 6'b000100;
            32'd14:       return 6'b001000;
            default:      return 6'b100000;
        endcase
    endfunction

    function automatic logic [5:0] decode_end(input logic [CNT_W-1:0] n);
        logic [31:0] v;
        v = 32'(n);
        case (v)
            32'd0:   return 6'b000000;
            32'd2:   return 6'b010000;
            default: return 6'b100000;
        endcase
    endfunction

`ifdef FRAME_DECODER_TIMEOUT_EN
    logic [15:0] tmo_q  = '0;
    logic        terr_q = 1'b0;
    logic        terr_d;
    logic        tmo_hit;

    assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));

    // Free-running while a pattern is open; held at zero otherwise so entry always starts from 0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q  <= (state_q == START_CNT || state_q == END_CNT) ? tmo_q + 16'd1 : 16'd0;
            terr_q <= terr_d;
        end
    end

    assign timeout_error = terr_q;
`else
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_eval = cnt_q;
        pulse_d  = '0;
        last_d   = last_q;
`ifdef FRAME_DECODER_TIMEOUT_EN
        terr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sdcka_negedge && !sdckb_negedge) begin
                    state_d = START_CNT;
                    cnt_d   = '0;
                end else if (sdckb_negedge && !sdcka_negedge) begin
                    state_d = END_CNT;
                    cnt_d   = '0;
                end
            end
            START_CNT: begin
                // A counting edge coincident with the close is part of the evaluated count.
                cnt_eval = sdckb_negedge ? sat_inc(cnt_q) : cnt_q;
                cnt_d    = cnt_eval;
                if (sdcka_posedge) begin
                    state_d = DONE;
                    pulse_d = decode_start(cnt_eval);
                    last_d  = cnt_eval;
                end
`ifdef FRAME_DECODER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = DONE;
                    terr_d  = 1'b1;
                    last_d  = cnt_eval;
                end
`endif
            end
            END_CNT: begin
                cnt_eval = sdcka_negedge ? sat_inc(cnt_q) : cnt_q;
                cnt_d    = cnt_eval;
                if (sdckb_posedge) begin
                    state_d = DONE;
                    pulse_d = decode_end(cnt_eval);
                    last_d  = cnt_eval;
                end
`ifdef FRAME_DECODER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = DONE;
                    terr_d  = 1'b1;
                    last_d  = cnt_eval;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == START_CNT) || (state_d == END_CNT);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign start_frame     = pulse_q[0];
    assign start_with_crc  = pulse_q[1];
    assign start_occupancy = pulse_q[2];
    assign start_reset     = pulse_q[3];
    assign end_frame       = pulse_q[4];
    assign pattern_error   = pulse_q[5];
    assign busy            = busy_q;
    assign last_count      = last_q;

endmodule

// File: tb/tb_frame_pattern_decoder.sv
// Bench for frame_pattern_decoder: pattern-level reference model checked every cycle plus directed literal checks.
module tb_frame_pattern_decoder;
    localparam int CNT_W  = 8;
    localparam int TO_CYC = 16;
    localparam logic [3:0] AP = 4'b1000, AN = 4'b0100, BP = 4'b0010, BN = 4'b0001, NO = 4'b0000;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic a_pos = 1'b0, a_neg = 1'b0, b_pos = 1'b0, b_neg = 1'b0;
    logic s_frame, s_crc, s_occ, s_rst, e_frame, p_err, t_err, busy;
    logic [CNT_W-1:0] last_count;
    logic [6:0] dut_vec;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    frame_pattern_decoder #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .sdcka_posedge(a_pos), .sdcka_negedge(a_neg),
        .sdckb_posedge(b_pos), .sdckb_negedge(b_neg),
        .start_frame(s_frame), .start_with_crc(s_crc), .start_occupancy(s_occ),
        .start_reset(s_rst), .end_frame(e_frame), .pattern_error(p_err),
        .timeout_error(t_err), .busy(busy), .last_count(last_count)
    );

    // {timeout, error, end, reset, occupancy, crc, frame}
    assign dut_vec = {t_err, p_err, e_frame, s_rst, s_occ, s_crc, s_frame};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pattern kind (0 none, 1 start, 2 end), edge tally, open-cycle tally.
    int         m_mode = 0, m_cnt = 0, m_open = 0;
    bit         m_done = 0;
    logic [6:0] m_pulse = '0;
    logic       m_busy = 1'b0;
    int         m_last = 0;

    function automatic logic [6:0] m_decode(input int mode, input int n);
        if (mode == 1) begin
            if (n == 4) return 7'b0000001;
            if (n == 6) return 7'b0000010;
            if (n == 8) return 7'b0000100;
            if (n == 14) return 7'b0001000;
            if (n <= 1) return 7'b0000000;
            return 7'b0100000;
        end
        if (n == 2) return 7'b0010000;
        if (n == 0) return 7'b0000000;
        return 7'b0100000;
    endfunction

    always @(posedge aclk) begin
        int n;
        bit counting, closing;
        if (!aresetn) begin
            m_mode = 0; m_cnt = 0; m_open = 0; m_done = 0;
            m_pulse = '0; m_last = 0;
        end else begin
            m_pulse = '0;
            if (m_done) begin
                m_done = 0;
            end else if (m_mode == 0) begin
                if (a_neg && !b_neg) begin m_mode = 1; m_cnt = 0; m_open = 0; end
                else if (b_neg && !a_neg) begin m_mode = 2; m_cnt = 0; m_open = 0; end
            end else begin
                counting = (m_mode == 1) ? b_neg : a_neg;
                closing  = (m_mode == 1) ? a_pos : b_pos;
                n = m_cnt + (counting ? 1 : 0);
                if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
                if (closing) begin
                    m_pulse = m_decode(m_mode, n);
                    m_last = n; m_mode = 0; m_done = 1;
                end
`ifdef FRAME_DECODER_TIMEOUT_EN
                else if (m_open == TO_CYC - 1) begin
                    m_pulse = 7'b1000000;
                    m_last = n; m_mode = 0; m_done = 1;
                end
`endif
                else begin
                    m_cnt = n;
                    m_open++;
                end
            end
        end
        m_busy = (m_mode != 0);
    end

    always @(negedge aclk) begin
        chk("cyc_pulses", 32'(dut_vec), 32'(m_pulse));
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_last_count", 32'(last_count), 32'(m_last));
    end

    task automatic cyc(input logic [3:0] s);
        @(posedge aclk);
        #1;
        {a_pos, a_neg, b_pos, b_neg} = s;
    endtask

    task automatic start_pat(input int n);
        cyc(AN);
        repeat (n) begin cyc(BN); cyc(NO); end
        cyc(AP);
        cyc(NO);
    endtask

    task automatic end_pat(input int n);
        cyc(BN);
        repeat (n) begin cyc(AN); cyc(NO); end
        cyc(BP);
        cyc(NO);
    endtask

    int         tcnt[5] = '{6, 8, 14, 5, 1};
    logic [6:0] texp[5] = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0100000, 7'b0000000};

    initial begin
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_last", 32'(last_count), 0);
        chk("reset_pulses", 32'(dut_vec), 0);

        start_pat(4);
        chk("sf4_pulse", 32'(dut_vec), 32'h01);
        chk("sf4_last", 32'(last_count), 4);
        cyc(NO);
        chk("sf4_one_cycle", 32'(dut_vec), 0);
        chk("sf4_last_hold", 32'(last_count), 4);

        for (int i = 0; i < 5; i++) begin
            start_pat(tcnt[i]);
            chk($sformatf("start_cnt%0d_pulse", tcnt[i]), 32'(dut_vec), 32'(texp[i]));
            chk($sformatf("start_cnt%0d_last", tcnt[i]), 32'(last_count), 32'(tcnt[i]));
        end

        end_pat(2);
        chk("end2_pulse", 32'(dut_vec), 32'h10);
        chk("end2_last", 32'(last_count), 2);
        end_pat(3);
        chk("end3_pulse", 32'(dut_vec), 32'h20);
        chk("end3_last", 32'(last_count), 3);
        end_pat(0);
        chk("end0_pulse", 32'(dut_vec), 0);
        chk("end0_last", 32'(last_count), 0);

        cyc(AN);
        repeat (3) begin cyc(BN); cyc(NO); end
        cyc(AP | BN);
        cyc(NO);
        chk("same_cycle_pulse", 32'(dut_vec), 32'h01);
        chk("same_cycle_last", 32'(last_count), 4);

        cyc(AN);
        repeat (4) begin cyc(BN); cyc(NO); end
        cyc(AP);
        cyc(AN);
        cyc(NO);
        chk("done_ignores_busy", 32'(busy), 0);
        cyc(NO);
        chk("done_ignores_idle", 32'(busy), 0);

        cyc(AN);
        repeat (3) begin cyc(BN); cyc(NO); end
        chk("pre_reset_busy", 32'(busy), 1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_last", 32'(last_count), 0);
        chk("mid_reset_pulses", 32'(dut_vec), 0);
        repeat (3) begin
            cyc(NO);
            chk("post_reset_no_pulse", 32'(dut_vec), 0);
        end
        start_pat(4);
        chk("post_reset_sf_pulse", 32'(dut_vec), 32'h01);
        chk("post_reset_sf_last", 32'(last_count), 4);

`ifdef FRAME_DECODER_TIMEOUT_EN
        cyc(AN);
        cyc(NO);
        repeat (TO_CYC - 1) cyc(NO);
        chk("timeout_not_early", 32'(t_err), 0);
        chk("timeout_busy_open", 32'(busy), 1);
        cyc(NO);
        chk("timeout_pulses", 32'(dut_vec), 32'h40);
        chk("timeout_busy_low", 32'(busy), 0);
        chk("timeout_last", 32'(last_count), 0);
`else
        cyc(AN);
        repeat (100) cyc(NO);
        chk("no_timeout_pulses", 32'(dut_vec), 0);
        chk("no_timeout_busy", 32'(busy), 1);
        cyc(AP);
        cyc(NO);
        chk("late_close_pulses", 32'(dut_vec), 0);
        chk("late_close_busy", 32'(busy), 0);
`endif

        repeat (3) cyc(NO);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_pattern_decoder.md
FRAME_PATTERN_DECODER -- requirements
Module: frame_pattern_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, width of the edge counter and last_count.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum number of aclk cycles a pattern may stay open; legal range is 2 to 65535.
REQ-003 The block SHALL have the following ports, one per line, as name, direction, width and meaning:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low; clock aclk.
- sdcka_posedge, sdcka_negedge  in  1 each  single-cycle SDCKA edge strobes.
- sdckb_posedge, sdckb_negedge  in  1 each  single-cycle SDCKB edge strobes.
- start_frame, start_with_crc, start_occupancy, start_reset  out  1 each  start-pattern pulses.
- end_frame  out  1  end-pattern pulse.
- pattern_error  out  1  pulse for a closed pattern with an illegal count.
- timeout_error  out  1  pulse for a pattern aborted by timeout.
- busy  out  1  high while a pattern is open (state START_CNT or END_CNT).
- last_count  out  CNT_W  count of the most recently closed or aborted pattern.

Function
REQ-004 The FSM SHALL have exactly four states, IDLE, START_CNT, END_CNT and DONE, with a one-hot encoding.
REQ-005 From IDLE, the FSM SHALL go to START_CNT on sdcka_negedge alone, go to END_CNT on sdckb_negedge alone, and stay in IDLE with no output when both strobes or neither strobe are asserted.
REQ-006 In START_CNT, each sdckb_negedge SHALL increment the counter, and sdcka_posedge SHALL close the pattern and move the FSM to DONE.
REQ-007 In END_CNT, each sdcka_negedge SHALL increment the counter, and sdckb_posedge SHALL close the pattern and move the FSM to DONE.
REQ-008 When a counting edge and the closing edge occur in the same cycle, the counting edge SHALL be included in the evaluated count.
REQ-009 The counter SHALL saturate at 2^CNT_W-1, SHALL never wrap, and SHALL clear on entry to START_CNT or END_CNT.
REQ-010 DONE SHALL last exactly one cycle, SHALL return to IDLE, and SHALL ignore all edge strobes.
REQ-011 A closed START pattern SHALL be decoded as follows: count 4 gives start_frame, 6 gives start_with_crc, 8 gives start_occupancy, 14 gives start_reset, 0 or 1 is silently ignored, and any other count gives pattern_error.
REQ-012 A closed END pattern SHALL be decoded as follows: count 2 gives end_frame, 0 is silently ignored, and any other count gives pattern_error.
REQ-013 All outputs SHALL be registered, and a pulse SHALL be high for exactly one cycle, namely the cycle after the aclk edge at which the closing strobe is sampled.
REQ-014 At most one of the seven pulse outputs SHALL be high in any cycle.
REQ-015 last_count SHALL update in the same cycle as the result pulse, including silently ignored counts and timeouts, and SHALL hold its value otherwise.
REQ-016 busy SHALL be registered and SHALL be high in every cycle in which the state is START_CNT or END_CNT.

Reset
REQ-017 While aresetn is low at a rising edge of aclk, the state SHALL become IDLE, and the counter, all pulses, busy, last_count and the timeout counter SHALL become 0.
REQ-018 An assertion of reset while a pattern is open SHALL abandon that pattern with no pulse output, either during or after reset.
REQ-019 The block SHALL also define all register values through initial values that equal their reset values.

Configuration
REQ-020 When macro FRAME_DECODER_TIMEOUT_EN is defined, a 16-bit cycle counter SHALL clear on entry to START_CNT or END_CNT and increment every cycle while the pattern is open.
REQ-021 With FRAME_DECODER_TIMEOUT_EN defined, if the cycle counter reaches TIMEOUT_CYCLES-1 without a closing edge, the FSM SHALL go to DONE and pulse timeout_error only, with no decode.
REQ-022 With FRAME_DECODER_TIMEOUT_EN defined, a closing edge in the same cycle as the timeout SHALL win, and the pattern SHALL decode normally.
REQ-023 Without FRAME_DECODER_TIMEOUT_EN, the block SHALL have no timeout logic, timeout_error SHALL be tied to 0, and patterns SHALL stay open indefinitely.

Verification
REQ-024 The bench SHALL drive a negedge, then 4 separate sdckb_negedge strobes, then sdcka_posedge, and SHALL check one start_frame pulse one cycle after the posedge, with last_count equal to 4.
REQ-025 The bench SHALL drive patterns with counts 6, 8, 14, 5 and 1, and SHALL check start_with_crc, start_occupancy, start_reset, pattern_error and no pulse respectively, with last_count updated each time.
REQ-026 The bench SHALL drive an sdckb_negedge, 2 sdcka_negedge strobes and an sdckb_posedge, SHALL check end_frame, and SHALL check that 3 sdcka_negedge strobes give pattern_error.
REQ-027 The bench SHALL drive 3 counted edges and then a 4th counted edge in the same cycle as the closing edge, and SHALL check start_frame.
REQ-028 The bench SHALL assert aresetn low for 1 cycle after 3 counted edges, SHALL check that busy and last_count are 0 and no pulse occurs, and SHALL check that a following full count-4 pattern still gives start_frame.
REQ-029 With FRAME_DECODER_TIMEOUT_EN defined and TIMEOUT_CYCLES equal to 16, the bench SHALL open a pattern, drive no closing edge, and check timeout_error 16 cycles after the opening edge, with busy then low; a bench without the macro SHALL check that no pulse occurs after 100 cycles.
